// File: rtl/mem_arb_pkg.sv
// Shared types and policy constants for the memory read/write port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int PRIO_RR      = 0;
  localparam int PRIO_FIXED_B = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way read-port arbiter: round-robin or fixed priority to B, one-hot grant.
// rr_q   | meaning
// REQ_A  | A wins the next two-way contention
// REQ_B  | B wins the next two-way contention
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e rr_q;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      if (PRIO_MODE == PRIO_FIXED_B || rr_q == REQ_B) gnt_o = 2'b10;
      else                                            gnt_o = 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  // Pointer moves to whichever side lost (or did not ask) after every read grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= REQ_A;
    end else if (PRIO_MODE == PRIO_RR && gnt_o != 2'b00) begin
      rr_q <= gnt_o[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a 1R/1W word memory between instruction fetch (A, read-only) and the
// LSU (B, read/write); read data returns one cycle after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 1024,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       a_req_i,
  input  logic [$clog2(DEPTH)-1:0]   a_addr_i,
  output logic                       a_gnt_o,
  output logic                       a_rvalid_o,
  output logic [WIDTH-1:0]           a_rdata_o,
  input  logic                       b_req_i,
  input  logic                       b_we_i,
  input  logic [$clog2(DEPTH)-1:0]   b_addr_i,
  input  logic [WIDTH-1:0]           b_wdata_i,
  output logic                       b_gnt_o,
  output logic                       b_rvalid_o,
  output logic [WIDTH-1:0]           b_rdata_o,
  output logic                       mem_read_en_o,
  output logic [$clog2(DEPTH)-1:0]   mem_read_pos_o,
  input  logic [WIDTH-1:0]           mem_read_data_i,
  output logic                       mem_write_en_o,
  output logic [$clog2(DEPTH)-1:0]   mem_write_pos_o,
  output logic [WIDTH-1:0]           mem_write_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic       b_wr;
  logic [1:0] rd_req;
  logic [1:0] rd_gnt;

  req_id_e rsp_owner_q;
  logic    rsp_pend_q;

  assign b_wr   = b_req_i & b_we_i & ~rst_i;
  assign rd_req = {b_req_i & ~b_we_i, a_req_i} & {2{~rst_i}};

  rr_arbiter2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_rr_arbiter2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (rd_req),
    .gnt_o (rd_gnt)
  );

  always_comb begin
    a_gnt_o          = rd_gnt[0];
    b_gnt_o          = rd_gnt[1] | b_wr;
    mem_read_en_o    = |rd_gnt;
    mem_read_pos_o   = '0;
    mem_write_en_o   = b_wr;
    mem_write_pos_o  = '0;
    mem_write_data_o = '0;
    if (rd_gnt[1])      mem_read_pos_o = b_addr_i;
    else if (rd_gnt[0]) mem_read_pos_o = a_addr_i;
    if (b_wr) begin
      mem_write_pos_o  = b_addr_i;
      mem_write_data_o = b_wdata_i;
    end
  end

  // Fixed one-cycle latency lets a single owner/pending pair track the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= REQ_A;
    end else begin
      rsp_pend_q <= |rd_gnt;
      if (|rd_gnt) rsp_owner_q <= rd_gnt[1] ? REQ_B : REQ_A;
    end
  end

  always_comb begin
    a_rvalid_o = rsp_pend_q & (rsp_owner_q == REQ_A) & ~rst_i;
    b_rvalid_o = rsp_pend_q & (rsp_owner_q == REQ_B) & ~rst_i;
    a_rdata_o  = a_rvalid_o ? mem_read_data_i : '0;
    b_rdata_o  = b_rvalid_o ? mem_read_data_i : '0;
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin (dut0) and fixed-B (dut1) arbiters, each with a
// 1-cycle-latency write-forwarding memory model.
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             a_req;
  logic [AW-1:0]    a_addr;
  logic             b_req;
  logic             b_we;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_wdata;

  logic             a_gnt0, a_rvalid0, b_gnt0, b_rvalid0;
  logic [WIDTH-1:0] a_rdata0, b_rdata0;
  logic             m0_re, m0_we;
  logic [AW-1:0]    m0_rpos, m0_wpos;
  logic [WIDTH-1:0] m0_rdata, m0_wdata;

  logic             a_gnt1, a_rvalid1, b_gnt1, b_rvalid1;
  logic [WIDTH-1:0] a_rdata1, b_rdata1;
  logic             m1_re, m1_we;
  logic [AW-1:0]    m1_rpos, m1_wpos;
  logic [WIDTH-1:0] m1_rdata, m1_wdata;

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_gnt_o(a_gnt0),
    .a_rvalid_o(a_rvalid0), .a_rdata_o(a_rdata0),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt0), .b_rvalid_o(b_rvalid0), .b_rdata_o(b_rdata0),
    .mem_read_en_o(m0_re), .mem_read_pos_o(m0_rpos), .mem_read_data_i(m0_rdata),
    .mem_write_en_o(m0_we), .mem_write_pos_o(m0_wpos), .mem_write_data_o(m0_wdata)
  );

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_gnt_o(a_gnt1),
    .a_rvalid_o(a_rvalid1), .a_rdata_o(a_rdata1),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt1), .b_rvalid_o(b_rvalid1), .b_rdata_o(b_rdata1),
    .mem_read_en_o(m1_re), .mem_read_pos_o(m1_rpos), .mem_read_data_i(m1_rdata),
    .mem_write_en_o(m1_we), .mem_write_pos_o(m1_wpos), .mem_write_data_o(m1_wdata)
  );

  always @(posedge clk) begin
    if (m0_re) m0_rdata <= (m0_we && m0_wpos == m0_rpos) ? m0_wdata : mem0[m0_rpos];
    if (m0_we) mem0[m0_wpos] <= m0_wdata;
  end

  always @(posedge clk) begin
    if (m1_re) m1_rdata <= (m1_we && m1_wpos == m1_rpos) ? m1_wdata : mem1[m1_rpos];
    if (m1_we) mem1[m1_wpos] <= m1_wdata;
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic b_write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    idle();
    b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = data;
    #1;
    chk("bw_gnt", b_gnt0, 1);
    chk("bw_wen", m0_we, 1);
    chk("bw_wpos", m0_wpos, addr);
    chk("bw_wdata", m0_wdata, data);
    chk("bw_ren", m0_re, 0);
    @(negedge clk);
    chk("bw_no_rvalid", b_rvalid0, 0);
  endtask

  initial begin
    // Requests asserted during reset must see no grants or enables.
    rst = 1'b1;
    idle();
    a_req = 1'b1; a_addr = 4'd1; b_req = 1'b1; b_addr = 4'd2;
    #1;
    chk("rst_a_gnt", a_gnt0, 0);
    chk("rst_b_gnt", b_gnt0, 0);
    chk("rst_ren", m0_re, 0);
    chk("rst_rpos", m0_rpos, 0);
    chk("rst_a_rvalid", a_rvalid0, 0);
    chk("rst_a_rdata", a_rdata0, 0);
    chk("rst_b_rdata", b_rdata0, 0);
    b_we = 1'b1;
    #1;
    chk("rst_wen", m0_we, 0);
    chk("rst_wpos", m0_wpos, 0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    b_write(4'd5, 32'hDEADBEEF);
    b_write(4'd1, 32'h11111111);
    b_write(4'd2, 32'h22222222);

    // A alone reads addr 5.
    idle();
    a_req = 1'b1; a_addr = 4'd5;
    #1;
    chk("a_only_gnt", a_gnt0, 1);
    chk("a_only_ren", m0_re, 1);
    chk("a_only_rpos", m0_rpos, 5);
    @(negedge clk);
    chk("a_only_rvalid", a_rvalid0, 1);
    chk("a_only_rdata", a_rdata0, 32'hDEADBEEF);
    chk("a_only_b_rvalid", b_rvalid0, 0);
    chk("a_only_b_rdata", b_rdata0, 0);

    // A granted, then async reset before the next edge drops the response.
    idle();
    a_req = 1'b1; a_addr = 4'd1;
    #1;
    chk("rstmid_gnt", a_gnt0, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_gnt_forced", a_gnt0, 0);
    chk("rstmid_ren_forced", m0_re, 0);
    idle();
    @(negedge clk);
    chk("rstmid_rvalid", a_rvalid0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rvalid_post", a_rvalid0, 0);
    chk("rstmid_b_rvalid_post", b_rvalid0, 0);

    // Continuous two-way contention from reset.
    a_req = 1'b1; a_addr = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_a_gnt%0d", i), a_gnt0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_b_gnt%0d", i), b_gnt0, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_rpos%0d", i), m0_rpos, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("fx_a_gnt%0d", i), a_gnt1, 0);
      chk($sformatf("fx_b_gnt%0d", i), b_gnt1, 1);
      @(negedge clk);
      chk($sformatf("rr_a_rvalid%0d", i), a_rvalid0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_a_rdata%0d", i), a_rdata0, (i % 2 == 0) ? 32'h11111111 : 32'h0);
      chk($sformatf("rr_b_rvalid%0d", i), b_rvalid0, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_b_rdata%0d", i), b_rdata0, (i % 2 == 1) ? 32'h22222222 : 32'h0);
      chk($sformatf("fx_b_rvalid%0d", i), b_rvalid1, 1);
      chk($sformatf("fx_b_rdata%0d", i), b_rdata1, 32'h22222222);
      chk($sformatf("fx_a_rvalid%0d", i), a_rvalid1, 0);
    end
    b_req = 1'b0;
    #1;
    chk("fx_a_gnt_after_b_drop", a_gnt1, 1);
    @(negedge clk);
    chk("fx_a_rvalid_after_b_drop", a_rvalid1, 1);
    chk("fx_a_rdata_after_b_drop", a_rdata1, 32'h11111111);

    // A read and B write to the same address in one cycle.
    idle();
    a_req = 1'b1; a_addr = 4'd7;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 32'h12345678;
    #1;
    chk("same_a_gnt", a_gnt0, 1);
    chk("same_b_gnt", b_gnt0, 1);
    chk("same_wen", m0_we, 1);
    @(negedge clk);
    chk("same_a_rvalid", a_rvalid0, 1);
    chk("same_a_rdata", a_rdata0, 32'h12345678);
    chk("same_b_rvalid", b_rvalid0, 0);
    idle();
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    #1;
    chk("same_b_read_gnt", b_gnt0, 1);
    @(negedge clk);
    chk("same_b_read_rvalid", b_rvalid0, 1);
    chk("same_b_read_rdata", b_rdata0, 32'h12345678);

    // B write then immediate B read of the same address.
    idle();
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd3; b_wdata = 32'hCAFEF00D;
    #1;
    chk("wr3_gnt", b_gnt0, 1);
    @(negedge clk);
    chk("wr3_no_rvalid", b_rvalid0, 0);
    b_we = 1'b0;
    #1;
    chk("rd3_gnt", b_gnt0, 1);
    chk("rd3_wen", m0_we, 0);
    @(negedge clk);
    chk("rd3_rvalid", b_rvalid0, 1);
    chk("rd3_rdata", b_rdata0, 32'hCAFEF00D);
    chk("rd3_a_rvalid", a_rvalid0, 0);
    idle();
    @(negedge clk);
    chk("idle_b_rvalid", b_rvalid0, 0);
    chk("idle_b_rdata", b_rdata0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-read-port / single-write-port word memory between two requesters:
  - port A: instruction fetch, read-only.
  - port B: load/store unit, read or write.
- Arbitrates the read port (round-robin or fixed priority).
- Passes B writes straight to the independent write port.
- Routes the 1-cycle-latency read data back to whichever requester was granted.
- Sits between the core front-end/LSU and the memory block.

Parameters:
- WIDTH, 32, data word width; must match memory WIDTH.
- DEPTH, 1024, memory words; address width AW = $clog2(DEPTH).
- PRIO_MODE, 0, read-port policy: 0 = round-robin, 1 = fixed priority to B.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- a_req_i  in  1  A read request; held with a_addr_i until granted
- a_addr_i  in  AW  A read word address
- a_gnt_o  out  1  A request accepted this cycle
- a_rvalid_o  out  1  A read data valid
- a_rdata_o  out  WIDTH  A read data
- b_req_i  in  1  B request; held with b_we_i/b_addr_i/b_wdata_i until granted
- b_we_i  in  1  B access type: 1 = write, 0 = read
- b_addr_i  in  AW  B word address
- b_wdata_i  in  WIDTH  B write data
- b_gnt_o  out  1  B request accepted this cycle
- b_rvalid_o  out  1  B read data valid (reads only)
- b_rdata_o  out  WIDTH  B read data
- mem_read_en_o  out  1  to memory read_en
- mem_read_pos_o  out  AW  to memory read_pos
- mem_read_data_i  in  WIDTH  from memory read_data
- mem_write_en_o  out  1  to memory write_en
- mem_write_pos_o  out  AW  to memory write_pos
- mem_write_data_o  out  WIDTH  to memory write_data

Behaviour:
- Grants are combinational from the current requests and rr_q. A request is accepted in the cycle its gnt is high; requester may change inputs next cycle.
- While rst_i is high, all gnt, enable and rvalid outputs are forced to 0.
- B write (b_req_i & b_we_i):
  - Always granted the same cycle.
  - Drives mem_write_en_o = 1 with b_addr_i / b_wdata_i.
  - Never uses the read port, never produces b_rvalid_o, does not touch rr_q.
- Read contenders are a_req_i and (b_req_i & ~b_we_i). At most one read is granted per cycle.
  - Sole contender: granted.
  - Both, PRIO_MODE = 0: rr_q holder granted.
  - Both, PRIO_MODE = 1: B granted.
  - Granted read drives mem_read_en_o = 1 and mem_read_pos_o = its address.
- rr_q (1 bit, reset = A-priority), PRIO_MODE = 0 only: after any granted read, rr_q points to the non-granted requester. No read grant means rr_q is held.
- Response routing:
  - rsp_owner_q and rsp_pend_q are registered on each read grant; reset pend = 0.
  - Next cycle: rvalid of rsp_owner_q = 1, its rdata = mem_read_data_i (pass-through); the other rdata = 0.
  - Fixed latency: grant in cycle N gives rvalid in N+1.
  - Back-to-back grants every cycle are legal; no internal queue is needed.
- Same-cycle read (either port) and B write to the same address: both granted. The memory's write-forwarding returns the new b_wdata_i value next cycle.
- Reset values: rvalid outputs 0, rdata outputs 0, rr_q = A, rsp_pend_q = 0. Idle mem_*_pos/data outputs are driven 0.
- Reset asserted mid-operation: the pending response is dropped; no rvalid after reset deasserts until a new grant.
- Ungranted requests are not latched; the requester keeps asserting.

Decomposition:
- Package mem_arb_pkg:
  - enum req_id_e {REQ_A, REQ_B}
  - localparams PRIO_RR = 0, PRIO_FIXED_B = 1
- Sub-module rr_arbiter2:
  - Inputs: 2 request bits, PRIO_MODE.
  - Outputs: one-hot grant.
  - Owns rr_q.
  - mem_arbiter instantiates it for the read port.

Test Plan:
- A only reads addr 5 holding 0xDEADBEEF; cycle 0 a_gnt_o = 1 → cycle 1 a_rvalid_o = 1, a_rdata_o = 0xDEADBEEF, b_rvalid_o = 0.
- A and B both read continuously for 4 cycles, PRIO_MODE = 0, from reset → grants A,B,A,B; each rvalid lands one cycle after its grant with correct owner data.
- Same contention with PRIO_MODE = 1 → B granted every cycle, a_gnt_o stays 0 until B drops its request.
- A reads addr 7 while B writes 0x12345678 to addr 7 in the same cycle → both gnt = 1; next cycle a_rdata_o = 0x12345678; subsequent B read of 7 also returns 0x12345678.
- B write to addr 3 in cycle 0, B read of addr 3 in cycle 1 → b_rvalid_o in cycle 2 with the written value; no b_rvalid_o in cycle 1.
- Grant A read, assert rst_i asynchronously before the next edge → a_rvalid_o = 0 throughout, rr_q back to A, first post-reset contention grants A.
